rsa_montgomery_wrapper: RTL and testbench

- Command-driven Montgomery multiplier for the RSA datapath.
- A processor issues 32-bit commands on port1 and gets completion on port2.
- Wide operands enter on the bram_din bus; the result leaves on the bram_dout bus.
- Computes A·B·R⁻¹ mod M, with R = 2^RSA_BITS.

---
 rtl/rsa_montgomery_wrapper.sv | 144 ++++++++++++++
 tb/tb_rsa_montgomery_wrapper.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_montgomery_wrapper.sv
// Command-driven radix-2 Montgomery multiplier: result = A*B*2^-RSA_BITS mod M.
// Operands load over bram_din, the result is returned over bram_dout, commands arrive on port1.
module rsa_montgomery_wrapper #(
  parameter int RSA_BITS = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [RSA_BITS-1:0] bram_din,
  input  logic                bram_din_valid,
  output logic [RSA_BITS-1:0] bram_dout,
  output logic                bram_dout_valid,
  input  logic                bram_dout_read,
  input  logic [31:0]         port1_din,
  input  logic                port1_valid,
  output logic                port1_read,
  output logic                port2_valid,
  input  logic                port2_read
);

  localparam int TW = RSA_BITS + 2;
  localparam int CW = $clog2(RSA_BITS);

  localparam logic [7:0] OP_READ    = 8'd0;
  localparam logic [7:0] OP_COMPUTE = 8'd1;
  localparam logic [7:0] OP_WRITE   = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    COMPUTE,
    REDUCE,
    WRITE,
    DONE
  } state_t;

  state_t              state;
  logic [1:0]          sel;
  logic [RSA_BITS-1:0] a, b, m, result;
  logic [RSA_BITS-1:0] a_shift;
  logic [TW-1:0]       t;
  logic [CW-1:0]       i;

  logic [TW-1:0] t1, t2, t_next, m_ext, t_sub;
  logic          t_ge_m;
  logic          last_iter;
  logic          unused_bits;

  // A is consumed LSB-first from a shadow copy so the index never needs a wide mux.
  always_comb begin
    m_ext     = {2'b00, m};
    t1        = t + (a_shift[0] ? {2'b00, b} : '0);
    t2        = t1 + (t1[0] ? m_ext : '0);
    t_next    = {1'b0, t2[TW-1:1]};
    t_sub     = t - m_ext;
    t_ge_m    = (t >= m_ext);
    last_iter = (i == CW'(RSA_BITS - 1));
  end

  assign unused_bits = ^{port1_din[31:10], t_sub[TW-1:RSA_BITS], t2[0]};

  always_ff @(posedge clk) begin
    if (resetn) begin
      state           <= IDLE;
      sel             <= '0;
      a               <= '0;
      b               <= '0;
      m               <= '0;
      result          <= '0;
      a_shift         <= '0;
      t               <= '0;
      i               <= '0;
      bram_dout       <= '0;
      bram_dout_valid <= 1'b0;
      port1_read      <= 1'b0;
      port2_valid     <= 1'b0;
    end else begin
      port1_read <= 1'b0;
      case (state)
        IDLE: begin
          if (port1_valid && !port2_valid) begin
            port1_read <= 1'b1;
            sel        <= port1_din[9:8];
            case (port1_din[7:0])
              OP_READ: state <= RD_WAIT;
              OP_COMPUTE: begin
                t       <= '0;
                i       <= '0;
                a_shift <= a;
                state   <= COMPUTE;
              end
              OP_WRITE: begin
                bram_dout       <= result;
                bram_dout_valid <= 1'b1;
                state           <= WRITE;
              end
              default: begin
                port2_valid <= 1'b1;
                state       <= DONE;
              end
            endcase
          end
        end
        RD_WAIT: begin
          if (bram_din_valid) begin
            case (sel)
              2'd0:    a <= bram_din;
              2'd1:    b <= bram_din;
              2'd2:    m <= bram_din;
              default: ;
            endcase
            port2_valid <= 1'b1;
            state       <= DONE;
          end
        end
        COMPUTE: begin
          t       <= t_next;
          a_shift <= a_shift >> 1;
          i       <= i + CW'(1);
          if (last_iter) state <= REDUCE;
        end
        REDUCE: begin
          result      <= t_ge_m ? t_sub[RSA_BITS-1:0] : t[RSA_BITS-1:0];
          port2_valid <= 1'b1;
          state       <= DONE;
        end
        WRITE: begin
          if (bram_dout_read) begin
            bram_dout_valid <= 1'b0;
            port2_valid     <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (port2_read) begin
            port2_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_montgomery_wrapper.sv
// Bench for rsa_montgomery_wrapper at RSA_BITS=8: vector table, random vectors against
// a modular-arithmetic model, and handshake/reset corner sequences.
module tb_rsa_montgomery_wrapper;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] bram_din;
  logic         bram_din_valid;
  logic [N-1:0] bram_dout;
  logic         bram_dout_valid;
  logic         bram_dout_read;
  logic [31:0]  port1_din;
  logic         port1_valid;
  logic         port1_read;
  logic         port2_valid;
  logic         port2_read;

  always #5 clk = ~clk;

  rsa_montgomery_wrapper #(.RSA_BITS(N)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .bram_din        (bram_din),
    .bram_din_valid  (bram_din_valid),
    .bram_dout       (bram_dout),
    .bram_dout_valid (bram_dout_valid),
    .bram_dout_read  (bram_dout_read),
    .port1_din       (port1_din),
    .port1_valid     (port1_valid),
    .port1_read      (port1_read),
    .port2_valid     (port2_valid),
    .port2_read      (port2_read)
  );

  int passed = 0;
  int total  = 0;
  int p1_count = 0;
  int p2_rises = 0;
  logic p2_prev = 1'b0;

  always @(negedge clk) begin
    if (port1_read) p1_count++;
    if (port2_valid && !p2_prev) p2_rises++;
    p2_prev = port2_valid;
  end

  typedef struct {
    int a;
    int b;
    int m;
    int exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // x such that x*2^N == a*b (mod m), found by search
  function automatic int mont_model(input int a, input int b, input int m);
    int ab;
    ab = (a * b) % m;
    for (int x = 0; x < m; x++)
      if (((x * (1 << N)) % m) == ab) return x;
    return -1;
  endfunction

  task automatic issue_cmd(input logic [31:0] w);
    int ok;
    ok = 0;
    port1_din   = w;
    port1_valid = 1'b1;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      tick();
      if (port1_read) ok = 1;
    end
    port1_valid = 1'b0;
    check("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic finish_cmd(output int cycles);
    cycles = 0;
    while (!port2_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    check("p2_timeout", 64'(port2_valid), 64'd1);
    repeat (2) tick();
    check("p2_hold", 64'(port2_valid), 64'd1);
    port2_read = 1'b1;
    repeat (3) tick();
    port2_read = 1'b0;
    check("p2_clear", 64'(port2_valid), 64'd0);
    tick();
  endtask

  task automatic load(input int s, input int val);
    int p1, p2, cyc;
    p1 = p1_count;
    p2 = p2_rises;
    issue_cmd({22'd0, 2'(s), 8'd0});
    bram_din       = N'(val);
    bram_din_valid = 1'b1;
    tick();
    bram_din_valid = 1'b0;
    bram_din       = N'($urandom);
    finish_cmd(cyc);
    check("load_p1_pulses", 64'(p1_count - p1), 64'd1);
    check("load_p2_rises", 64'(p2_rises - p2), 64'd1);
  endtask

  task automatic compute();
    int p1, p2, cyc;
    p1 = p1_count;
    p2 = p2_rises;
    issue_cmd(32'd1);
    finish_cmd(cyc);
    check("compute_latency", 64'(cyc), 64'(N + 1));
    check("compute_p1_pulses", 64'(p1_count - p1), 64'd1);
    check("compute_p2_rises", 64'(p2_rises - p2), 64'd1);
  endtask

  task automatic read_result(input int exp);
    int cyc;
    issue_cmd(32'd2);
    check("dout_valid_set", 64'(bram_dout_valid), 64'd1);
    check("dout_value", 64'(bram_dout), 64'(exp));
    repeat (2) tick();
    check("dout_hold", 64'({bram_dout_valid, port2_valid, bram_dout}), 64'({2'b10, N'(exp)}));
    bram_dout_read = 1'b1;
    tick();
    bram_dout_read = 1'b0;
    check("dout_valid_clear", 64'(bram_dout_valid), 64'd0);
    finish_cmd(cyc);
    check("dout_persist", 64'(bram_dout), 64'(exp));
  endtask

  task automatic run_vec(input int a, input int b, input int m, input int exp);
    load(0, a);
    load(1, b);
    load(2, m);
    compute();
    read_result(exp);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({bram_dout, bram_dout_valid, port1_read, port2_valid}), 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    int ra, rb, rm, p1;

    vecs[0] = '{a: 5,   b: 7,   m: 13,  exp: 1};
    vecs[1] = '{a: 9,   b: 7,   m: 13,  exp: 7};
    vecs[2] = '{a: 12,  b: 12,  m: 13,  exp: 3};
    vecs[3] = '{a: 1,   b: 1,   m: 241, exp: 8'hE1};
    vecs[4] = '{a: 15,  b: 15,  m: 241, exp: 15};
    vecs[5] = '{a: 0,   b: 0,   m: 241, exp: 0};
    vecs[6] = '{a: 254, b: 254, m: 255, exp: 1};

    resetn = 1'b1;
    bram_din = '0;
    bram_din_valid = 1'b0;
    bram_dout_read = 1'b0;
    port1_din = '0;
    port1_valid = 1'b0;
    port2_read = 1'b0;
    repeat (2) tick();
    check_outputs_zero("reset_outputs");
    resetn = 1'b0;
    tick();

    read_result(0);

    for (int v = 0; v < 7; v++)
      run_vec(vecs[v].a, vecs[v].b, vecs[v].m, vecs[v].exp);

    // sel=3 discards the word; stray bram_din_valid and bram_dout_read in IDLE are ignored
    load(3, 8'hAA);
    bram_din = 8'h55;
    bram_din_valid = 1'b1;
    bram_dout_read = 1'b1;
    tick();
    bram_din_valid = 1'b0;
    bram_dout_read = 1'b0;
    tick();
    check("idle_strays", 64'({bram_dout_valid, port2_valid, port1_read}), 64'd0);
    compute();
    read_result(1);

    for (int r = 0; r < 20; r++) begin
      rm = 2 * $urandom_range(1, 127) + 1;
      ra = $urandom_range(0, rm - 1);
      rb = $urandom_range(0, rm - 1);
      run_vec(ra, rb, rm, mont_model(ra, rb, rm));
    end

    // reset in the middle of COMPUTE: aborts with no completion, registers cleared
    load(0, 5);
    load(1, 7);
    load(2, 13);
    issue_cmd(32'd1);
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check_outputs_zero("midreset_outputs");
    resetn = 1'b0;
    repeat (N + 5) tick();
    check("midreset_no_done", 64'({port2_valid, port1_read}), 64'd0);
    read_result(0);
    run_vec(5, 7, 13, 1);

    // no-op presented while completion is pending waits for port2_read
    load(1, 7);
    load(2, 13);
    p1 = p1_count;
    issue_cmd({22'd0, 2'd0, 8'd0});
    bram_din = 8'd9;
    bram_din_valid = 1'b1;
    tick();
    bram_din_valid = 1'b0;
    for (int k = 0; k < 20 && !port2_valid; k++) tick();
    port1_din = 32'd7;
    port1_valid = 1'b1;
    repeat (4) tick();
    check("noop_blocked", 64'(p1_count - p1), 64'd1);
    port2_read = 1'b1;
    tick();
    port2_read = 1'b0;
    check("noop_p2_cleared", 64'(port2_valid), 64'd0);
    begin
      int ok;
      ok = 0;
      for (int k = 0; k < 20 && ok == 0; k++) begin
        tick();
        if (port1_read) ok = 1;
      end
      port1_valid = 1'b0;
      check("noop_accepted", 64'(ok), 64'd1);
    end
    begin
      int cyc;
      finish_cmd(cyc);
    end
    check("noop_p1_pulses", 64'(p1_count - p1), 64'd2);
    compute();
    read_result(7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
